hwag_coil_bank: RTL and testbench
=================================

Name: hwag_coil_bank

Overview:
- Parametrised N-channel ignition output stage for the hardware angle generator.
- Consumes the shared angle counter and drives one coil output per channel.
- Each channel has its own phase offset, ignition angle and dwell angle, with double-buffered (pending/active) registers that are committed only at safe points.
- Adds a per-channel dwell timeout with a latched fault; both are new against the fixed two-coil comparator logic.

Parameters:
- N_CH, 4: number of coil channels.
- AW, 24: angle width; must match the angle counter.
- MAXACR, 3839: last angle count of one cycle (cycle length MAXACR+1).
- TMO_W, 24: dwell timeout counter width.
- DWELL_TMO, 24'd400000: maximum coil-on time in clk cycles.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- run  in  1  angle generator synchronised (hwag_start).
- acnt  in  AW  angle counter value.
- acnt_step  in  1  acnt holds a new value this cycle.
- wr_en  in  1  write strobe (one-cycle).
- wr_ch  in  $clog2(N_CH)  target channel.
- wr_sel  in  2  0=ignition angle, 1=dwell angle, 2=offset, 3=reserved.
- wr_data  in  AW  value to write.
- wr_err  out  1  one-cycle pulse on a rejected write.
- fault_clr  in  N_CH  per-channel fault clear.
- coil_out  out  N_CH  coil drive, 1=charging.
- fault  out  N_CH  latched dwell-timeout fault.

Behaviour:
- Reset (synchronous, highest priority, also mid-operation):
  - coil_out=0, fault=0, wr_err=0, all channels in OFF.
  - Active and pending ign/dwell/offset = 0; pending flags = 0.
- Writes:
  - wr_en with wr_data>MAXACR, wr_ch>=N_CH or wr_sel=3: ignored, wr_err=1 next cycle.
  - Otherwise the selected pending register is loaded and the channel pending flag is set next cycle.
- Local angle, combinational:
  - la = acnt+offset, minus (MAXACR+1) if the sum exceeds MAXACR.
  - Computed at AW+1 bits, no overflow.
- Set point:
  - sp = ign-dwell if ign>=dwell, else ign+MAXACR+1-dwell.
  - Uses active values only.
- Commit (all three pending registers copied to active, pending flag cleared):
  - Allowed only in state OFF (every cycle), or on the DWELL->ARMED fire transition.
  - A write landing on the commit cycle stays pending; its flag remains set.
- Per-channel FSM, registered, evaluated each clk:
  - OFF: coil=0. Goes to ARMED when run=1 and active dwell!=0 (checked after same-cycle commit).
  - ARMED: coil=0.
    - run=0 -> OFF.
    - acnt_step & la==sp -> DWELL; coil=1 from the next cycle; timeout counter cleared.
  - DWELL: coil=1; timeout counter increments every clk.
    - run=0 -> OFF, coil=0 next cycle, no fault.
    - acnt_step & la==ign -> ARMED, coil=0 next cycle (fire), commit. If the newly active dwell=0, go to OFF instead.
    - Counter reaches DWELL_TMO-1 -> FAULT, coil=0, fault=1.
  - FAULT: coil=0, fault=1.
    - fault_clr[ch] -> OFF, fault=0 next cycle.
    - run has no effect in FAULT.
- Simultaneous events:
  - Fire and timeout on the same cycle: fire wins, no fault.
  - run=0 takes priority over set/fire.
  - fault_clr in a non-FAULT state is ignored.
- Event detection and latency:
  - Match is equality only. A jump of acnt (tooth resync reload) that skips sp or ign skips the event; the timeout covers a missed fire.
  - Latency: coil_out changes exactly 1 clk after the matching acnt_step cycle.
- Wrap-around: sp<ign and sp>ign (dwell across cycle zero) are both legal. dwell==MAXACR+1 is impossible by the write check.

Decomposition:
- Package hwag_pkg holds:
  - coil_state_t enum {OFF, ARMED, DWELL, FAULT}.
  - wr_sel encodings (WR_IGN, WR_DWELL, WR_OFFS).
  - Default AW and MAXACR constants.
- Sub-module hwag_coil_channel: one channel's pending/active registers, la/sp arithmetic, FSM and timeout counter.
- Top: write decode, wr_err, generate loop over N_CH.

Test Plan:
- Basic fire: N_CH=2, ch0 offset=0, ign=100, dwell=50, run=1, acnt stepped 0..3839 one per 4 clk.
  - coil_out[0] rises 1 clk after the acnt=50 step and falls 1 clk after the acnt=100 step.
- Phase offset: ch1 offset=1920, ign=100, dwell=50.
  - coil_out[1] rises after the acnt=1970 step and falls after the acnt=2020 step.
- Wrap: ch0 ign=20, dwell=50 (sp=3810).
  - Coil on at acnt=3810, stays on through 3839->0, off at acnt=20.
- Shadow: during DWELL write ign=200.
  - Fire still occurs at 100; the next cycle sets at 150 and fires at 200.
  - A write of 4000 gives a wr_err pulse, no change.
- Timeout: DWELL_TMO=1000; stop acnt_step after the set at 50.
  - coil_out[0] falls and fault[0]=1 exactly 1000 clk after the rise.
  - fault_clr[0] returns the channel to OFF, then ARMED.
- Run drop and reset: run=0 mid-DWELL gives coil=0 next clk, no fault.
  - rst asserted mid-DWELL clears coil_out, fault and all angle registers next clk.

Source files
------------

// File: rtl/hwag_pkg.sv
// Shared types and constants for the hardware angle generator coil bank.
package hwag_pkg;

  typedef enum logic [1:0] {
    OFF   = 2'd0,
    ARMED = 2'd1,
    DWELL = 2'd2,
    FAULT = 2'd3
  } coil_state_t;

  localparam logic [1:0] WR_IGN   = 2'd0;
  localparam logic [1:0] WR_DWELL = 2'd1;
  localparam logic [1:0] WR_OFFS  = 2'd2;
  localparam logic [1:0] WR_RSVD  = 2'd3;

  localparam int AW_DEF     = 24;
  localparam int MAXACR_DEF = 3839;

endpackage

// File: rtl/hwag_coil_channel.sv
// One ignition channel: shadowed angle registers, local-angle/set-point
// arithmetic, coil FSM and dwell timeout.
module hwag_coil_channel
  import hwag_pkg::*;
#(
  parameter int               AW        = AW_DEF,
  parameter int               MAXACR    = MAXACR_DEF,
  parameter int               TMO_W     = 24,
  parameter logic [TMO_W-1:0] DWELL_TMO = TMO_W'(400000)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          run,
  input  logic [AW-1:0] acnt,
  input  logic          acnt_step,
  input  logic          ld_en,
  input  logic [1:0]    ld_sel,
  input  logic [AW-1:0] ld_data,
  input  logic          fault_clr,
  output logic          coil,
  output logic          fault
);

  localparam logic [AW:0]      CYC      = (AW+1)'(MAXACR + 1);
  localparam logic [AW:0]      MAXV     = (AW+1)'(MAXACR);
  localparam logic [TMO_W-1:0] TMO_LAST = DWELL_TMO - TMO_W'(1);

  logic [AW-1:0]    pend_ign_r, pend_dwell_r, pend_offs_r;
  logic [AW-1:0]    act_ign_r, act_dwell_r, act_offs_r;
  logic             pend_flag_r;
  coil_state_t      state_r, state_s;
  logic [TMO_W-1:0] tmo_r;

  logic [AW:0]      la_sum_s, la_s, sp_s;
  logic             set_hit_s, fire_hit_s, tmo_hit_s, fire_evt_s, commit_s;
  logic [AW-1:0]    new_dwell_s;

  assign la_sum_s = {1'b0, acnt} + {1'b0, act_offs_r};
  assign la_s     = (la_sum_s > MAXV) ? (la_sum_s - CYC) : la_sum_s;

  // Set point wraps through zero when the dwell angle exceeds the ignition angle.
  assign sp_s = (act_ign_r >= act_dwell_r)
              ? ({1'b0, act_ign_r} - {1'b0, act_dwell_r})
              : ({1'b0, act_ign_r} + CYC - {1'b0, act_dwell_r});

  assign set_hit_s  = acnt_step && (la_s == sp_s);
  assign fire_hit_s = acnt_step && (la_s == {1'b0, act_ign_r});
  assign tmo_hit_s  = (tmo_r == TMO_LAST);
  assign fire_evt_s = (state_r == DWELL) && run && fire_hit_s;
  assign commit_s   = pend_flag_r && ((state_r == OFF) || fire_evt_s);
  assign new_dwell_s = commit_s ? pend_dwell_r : act_dwell_r;

  // Next-state logic; run=0 outranks events, fire outranks timeout.
  always_comb begin
    state_s = state_r;
    case (state_r)
      OFF: begin
        if (run && (new_dwell_s != {AW{1'b0}})) state_s = ARMED;
        else                                    state_s = OFF;
      end
      ARMED: begin
        if (!run)           state_s = OFF;
        else if (set_hit_s) state_s = DWELL;
        else                state_s = ARMED;
      end
      DWELL: begin
        if (!run)            state_s = OFF;
        else if (fire_hit_s) state_s = (new_dwell_s != {AW{1'b0}}) ? ARMED : OFF;
        else if (tmo_hit_s)  state_s = FAULT;
        else                 state_s = DWELL;
      end
      FAULT: begin
        if (fault_clr) state_s = OFF;
        else           state_s = FAULT;
      end
      default: state_s = OFF;
    endcase
  end

  // State register and registered coil/fault outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= OFF;
      coil    <= 1'b0;
      fault   <= 1'b0;
    end else begin
      state_r <= state_s;
      coil    <= (state_s == DWELL);
      fault   <= (state_s == FAULT);
    end
  end

  // Dwell timeout counter: held at zero outside DWELL.
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_r <= {TMO_W{1'b0}};
    end else if (state_r != DWELL) begin
      tmo_r <= {TMO_W{1'b0}};
    end else begin
      tmo_r <= tmo_r + TMO_W'(1);
    end
  end

  // Pending/active registers; a write on the commit cycle stays pending.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_ign_r   <= {AW{1'b0}};
      pend_dwell_r <= {AW{1'b0}};
      pend_offs_r  <= {AW{1'b0}};
      act_ign_r    <= {AW{1'b0}};
      act_dwell_r  <= {AW{1'b0}};
      act_offs_r   <= {AW{1'b0}};
      pend_flag_r  <= 1'b0;
    end else begin
      if (commit_s) begin
        act_ign_r   <= pend_ign_r;
        act_dwell_r <= pend_dwell_r;
        act_offs_r  <= pend_offs_r;
      end
      if (ld_en) begin
        case (ld_sel)
          WR_IGN:   pend_ign_r   <= ld_data;
          WR_DWELL: pend_dwell_r <= ld_data;
          WR_OFFS:  pend_offs_r  <= ld_data;
          default:  pend_ign_r   <= pend_ign_r;
        endcase
      end
      if (ld_en)         pend_flag_r <= 1'b1;
      else if (commit_s) pend_flag_r <= 1'b0;
      else               pend_flag_r <= pend_flag_r;
    end
  end

endmodule

// File: rtl/hwag_coil_bank.sv
// N-channel ignition output stage: write decode/validation and one
// hwag_coil_channel per coil.
module hwag_coil_bank
  import hwag_pkg::*;
#(
  parameter int               N_CH      = 4,
  parameter int               AW        = AW_DEF,
  parameter int               MAXACR    = MAXACR_DEF,
  parameter int               TMO_W     = 24,
  parameter logic [TMO_W-1:0] DWELL_TMO = TMO_W'(400000)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    run,
  input  logic [AW-1:0]           acnt,
  input  logic                    acnt_step,
  input  logic                    wr_en,
  input  logic [$clog2(N_CH)-1:0] wr_ch,
  input  logic [1:0]              wr_sel,
  input  logic [AW-1:0]           wr_data,
  output logic                    wr_err,
  input  logic [N_CH-1:0]         fault_clr,
  output logic [N_CH-1:0]         coil_out,
  output logic [N_CH-1:0]         fault
);

  localparam logic [AW-1:0] MAX_DATA = AW'(MAXACR);

  logic wr_ok_s;

  // Out-of-cycle angles are rejected so a dwell of a full cycle cannot exist.
  assign wr_ok_s = (wr_data <= MAX_DATA) && (32'(wr_ch) < N_CH) && (wr_sel != WR_RSVD);

  // One-cycle error pulse for rejected writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_err <= 1'b0;
    end else begin
      wr_err <= wr_en && !wr_ok_s;
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    hwag_coil_channel #(
      .AW        (AW),
      .MAXACR    (MAXACR),
      .TMO_W     (TMO_W),
      .DWELL_TMO (DWELL_TMO)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .run       (run),
      .acnt      (acnt),
      .acnt_step (acnt_step),
      .ld_en     (wr_en && wr_ok_s && (32'(wr_ch) == i)),
      .ld_sel    (wr_sel),
      .ld_data   (wr_data),
      .fault_clr (fault_clr[i]),
      .coil      (coil_out[i]),
      .fault     (fault[i])
    );
  end

endmodule

// File: tb/tb_hwag_coil_bank.sv
// Directed self-checking bench for hwag_coil_bank (2 channels, short timeout).
module tb_hwag_coil_bank;

  localparam int AW = 24;

  logic          clk = 1'b0;
  logic          rst, run, acnt_step, wr_en, wr_err;
  logic [AW-1:0] acnt, wr_data;
  logic [0:0]    wr_ch;
  logic [1:0]    wr_sel, fault_clr, coil_out, fault;

  int cmp  = 0;
  int errs = 0;

  hwag_coil_bank #(
    .N_CH(2), .AW(AW), .MAXACR(3839), .TMO_W(24), .DWELL_TMO(24'd1000)
  ) dut (
    .clk(clk), .rst(rst), .run(run), .acnt(acnt), .acnt_step(acnt_step),
    .wr_en(wr_en), .wr_ch(wr_ch), .wr_sel(wr_sel), .wr_data(wr_data),
    .wr_err(wr_err), .fault_clr(fault_clr), .coil_out(coil_out), .fault(fault)
  );

  always #5 clk = ~clk;

  // One acnt step lasting 4 clk; cb/ca are coil_out just before/after the step edge.
  task automatic step(input int v, output logic [1:0] cb, output logic [1:0] ca);
    @(negedge clk); cb = coil_out; acnt = AW'(v); acnt_step = 1'b1;
    @(negedge clk); ca = coil_out; acnt_step = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic run_to(input int from, input int to);
    int v;
    logic [1:0] b, a;
    v = from;
    while (1) begin
      step(v, b, a);
      if (v == to) break;
      v = (v == 3839) ? 0 : v + 1;
    end
  endtask

  task automatic wr(input int ch, input int sel, input int data, output logic err);
    @(negedge clk); wr_en = 1'b1; wr_ch = 1'(ch); wr_sel = 2'(sel); wr_data = AW'(data);
    @(negedge clk); wr_en = 1'b0; err = wr_err;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1; run = 1'b0; acnt = '0; acnt_step = 1'b0; wr_en = 1'b0;
    wr_ch = '0; wr_sel = '0; wr_data = '0; fault_clr = '0;
    idle(3);
    cmp++; if (coil_out !== 2'b00) begin errs++; $display("FAIL reset_coil: got %b want 00", coil_out); end
    cmp++; if (fault !== 2'b00) begin errs++; $display("FAIL reset_fault: got %b want 00", fault); end
    cmp++; if (wr_err !== 1'b0) begin errs++; $display("FAIL reset_wr_err: got %b want 0", wr_err); end
    rst = 1'b0;
    idle(1);
  endtask

  task automatic test_basic_fire;
    logic [1:0] b, a;
    logic e;
    run = 1'b1;
    wr(0, 0, 100, e);
    cmp++; if (e !== 1'b0) begin errs++; $display("FAIL basic_wr_ign_err: got %b want 0", e); end
    wr(0, 1, 50, e);
    cmp++; if (e !== 1'b0) begin errs++; $display("FAIL basic_wr_dwell_err: got %b want 0", e); end
    wr(0, 2, 0, e);
    idle(3);
    step(49, b, a);
    cmp++; if (a[0] !== 1'b0) begin errs++; $display("FAIL basic_pre_set: got %b want 0", a[0]); end
    step(50, b, a);
    cmp++; if (b[0] !== 1'b0 || a[0] !== 1'b1) begin errs++; $display("FAIL basic_rise: got %b->%b want 0->1", b[0], a[0]); end
    run_to(51, 99);
    step(100, b, a);
    cmp++; if (b[0] !== 1'b1 || a[0] !== 1'b0) begin errs++; $display("FAIL basic_fall: got %b->%b want 1->0", b[0], a[0]); end
    cmp++; if (a[1] !== 1'b0 || fault !== 2'b00) begin errs++; $display("FAIL basic_idle_ch1: got coil1=%b fault=%b want 0/00", a[1], fault); end
  endtask

  task automatic test_phase_offset;
    logic [1:0] b, a;
    logic e;
    wr(1, 2, 1920, e);
    wr(1, 0, 100, e);
    wr(1, 1, 50, e);
    idle(3);
    step(1969, b, a);
    cmp++; if (a[1] !== 1'b0) begin errs++; $display("FAIL phase_pre_set: got %b want 0", a[1]); end
    step(1970, b, a);
    cmp++; if (b[1] !== 1'b0 || a[1] !== 1'b1) begin errs++; $display("FAIL phase_rise: got %b->%b want 0->1", b[1], a[1]); end
    run_to(1971, 2019);
    step(2020, b, a);
    cmp++; if (b[1] !== 1'b1 || a[1] !== 1'b0) begin errs++; $display("FAIL phase_fall: got %b->%b want 1->0", b[1], a[1]); end
    cmp++; if (a[0] !== 1'b0) begin errs++; $display("FAIL phase_ch0_quiet: got %b want 0", a[0]); end
  endtask

  task automatic test_wrap;
    logic [1:0] b, a;
    logic e;
    run = 1'b0; idle(2);
    wr(0, 0, 20, e);
    idle(2); run = 1'b1; idle(3);
    step(3809, b, a);
    cmp++; if (a[0] !== 1'b0) begin errs++; $display("FAIL wrap_pre_set: got %b want 0", a[0]); end
    step(3810, b, a);
    cmp++; if (b[0] !== 1'b0 || a[0] !== 1'b1) begin errs++; $display("FAIL wrap_rise: got %b->%b want 0->1", b[0], a[0]); end
    run_to(3811, 3839);
    step(0, b, a);
    cmp++; if (a[0] !== 1'b1) begin errs++; $display("FAIL wrap_through_zero: got %b want 1", a[0]); end
    run_to(1, 19);
    step(20, b, a);
    cmp++; if (b[0] !== 1'b1 || a[0] !== 1'b0) begin errs++; $display("FAIL wrap_fall: got %b->%b want 1->0", b[0], a[0]); end
  endtask

  task automatic test_shadow;
    logic [1:0] b, a;
    logic e;
    run = 1'b0; idle(2);
    wr(0, 0, 100, e);
    idle(2); run = 1'b1; idle(3);
    step(49, b, a);
    step(50, b, a);
    cmp++; if (a[0] !== 1'b1) begin errs++; $display("FAIL shadow_rise1: got %b want 1", a[0]); end
    run_to(51, 60);
    wr(0, 0, 200, e);
    cmp++; if (e !== 1'b0) begin errs++; $display("FAIL shadow_wr_ok: got %b want 0", e); end
    wr(0, 0, 4000, e);
    cmp++; if (e !== 1'b1) begin errs++; $display("FAIL shadow_wr_range_err: got %b want 1", e); end
    @(negedge clk);
    cmp++; if (wr_err !== 1'b0) begin errs++; $display("FAIL shadow_err_pulse_len: got %b want 0", wr_err); end
    wr(0, 3, 5, e);
    cmp++; if (e !== 1'b1) begin errs++; $display("FAIL shadow_wr_sel3_err: got %b want 1", e); end
    run_to(61, 99);
    step(100, b, a);
    cmp++; if (b[0] !== 1'b1 || a[0] !== 1'b0) begin errs++; $display("FAIL shadow_old_fire: got %b->%b want 1->0", b[0], a[0]); end
    run_to(101, 149);
    step(150, b, a);
    cmp++; if (b[0] !== 1'b0 || a[0] !== 1'b1) begin errs++; $display("FAIL shadow_new_set: got %b->%b want 0->1", b[0], a[0]); end
    run_to(151, 199);
    step(200, b, a);
    cmp++; if (b[0] !== 1'b1 || a[0] !== 1'b0) begin errs++; $display("FAIL shadow_new_fire: got %b->%b want 1->0", b[0], a[0]); end
  endtask

  task automatic test_timeout;
    logic [1:0] b, a;
    @(negedge clk); acnt = AW'(150); acnt_step = 1'b1;
    @(negedge clk); acnt_step = 1'b0;
    cmp++; if (coil_out[0] !== 1'b1) begin errs++; $display("FAIL tmo_rise: got %b want 1", coil_out[0]); end
    idle(999);
    cmp++; if (coil_out[0] !== 1'b1 || fault[0] !== 1'b0) begin errs++; $display("FAIL tmo_before: got coil=%b fault=%b want 1/0", coil_out[0], fault[0]); end
    @(negedge clk);
    cmp++; if (coil_out[0] !== 1'b0 || fault[0] !== 1'b1) begin errs++; $display("FAIL tmo_expire: got coil=%b fault=%b want 0/1", coil_out[0], fault[0]); end
    run = 1'b0; idle(2);
    cmp++; if (fault[0] !== 1'b1) begin errs++; $display("FAIL tmo_run_ignored: got %b want 1", fault[0]); end
    run = 1'b1; idle(2);
    @(negedge clk); fault_clr = 2'b01;
    @(negedge clk); fault_clr = 2'b00;
    cmp++; if (fault[0] !== 1'b0) begin errs++; $display("FAIL tmo_clear: got %b want 0", fault[0]); end
    idle(3);
    step(149, b, a);
    step(150, b, a);
    cmp++; if (b[0] !== 1'b0 || a[0] !== 1'b1) begin errs++; $display("FAIL tmo_rearm: got %b->%b want 0->1", b[0], a[0]); end
    run_to(151, 199);
    step(200, b, a);
    cmp++; if (a[0] !== 1'b0 || fault[0] !== 1'b0) begin errs++; $display("FAIL tmo_refire: got coil=%b fault=%b want 0/0", a[0], fault[0]); end
  endtask

  task automatic test_run_drop;
    logic [1:0] b, a;
    step(149, b, a);
    step(150, b, a);
    @(negedge clk); run = 1'b0;
    cmp++; if (coil_out[0] !== 1'b1) begin errs++; $display("FAIL drop_before: got %b want 1", coil_out[0]); end
    @(negedge clk);
    cmp++; if (coil_out[0] !== 1'b0 || fault[0] !== 1'b0) begin errs++; $display("FAIL drop_after: got coil=%b fault=%b want 0/0", coil_out[0], fault[0]); end
    run = 1'b1; idle(3);
  endtask

  task automatic test_reset_mid;
    logic [1:0] b, a;
    logic e;
    wr(1, 2, 3839, e);
    cmp++; if (e !== 1'b0) begin errs++; $display("FAIL rst_wr_max_ok: got %b want 0", e); end
    wr(1, 2, 3840, e);
    cmp++; if (e !== 1'b1) begin errs++; $display("FAIL rst_wr_max1_err: got %b want 1", e); end
    step(149, b, a);
    step(150, b, a);
    cmp++; if (a[0] !== 1'b1) begin errs++; $display("FAIL rst_pre_dwell: got %b want 1", a[0]); end
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    cmp++; if (coil_out !== 2'b00 || fault !== 2'b00) begin errs++; $display("FAIL rst_mid: got coil=%b fault=%b want 00/00", coil_out, fault); end
    idle(3);
    step(150, b, a);
    cmp++; if (a !== 2'b00) begin errs++; $display("FAIL rst_regs_cleared: got %b want 00", a); end
    wr(0, 1, 50, e);
    idle(3);
    step(3789, b, a);
    step(3790, b, a);
    cmp++; if (b[0] !== 1'b0 || a[0] !== 1'b1) begin errs++; $display("FAIL rst_zero_ign_set: got %b->%b want 0->1", b[0], a[0]); end
    run_to(3791, 3839);
    step(0, b, a);
    cmp++; if (b[0] !== 1'b1 || a[0] !== 1'b0) begin errs++; $display("FAIL rst_zero_ign_fire: got %b->%b want 1->0", b[0], a[0]); end
  endtask

  initial begin
    test_reset;
    test_basic_fire;
    test_phase_offset;
    test_wrap;
    test_shadow;
    test_timeout;
    test_run_drop;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
    $finish;
  end

endmodule
